inst_fetch_unit: RTL and testbench

- Fetch stage between the PC logic and the instruction decoder of the 8-bit core.
- Drives the 12-bit address of the combinational program ROM (rom_blinky style: data valid in the same cycle as addr) and reads one byte per cycle.
- Assembles 1-3 byte instructions into an instruction register and hands them to the decoder over a valid/ready handshake.
- Accepts branch/jump redirects from execute and flushes any partial fetch.

---
 rtl/noobs_pkg.sv | 24 ++
 rtl/inst_fetch_unit.sv | 125 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/noobs_pkg.sv
// Shared definitions for the 8-bit core front end: widths, reset PC,
// fetch state encoding and instruction-length codes.
package noobs_pkg;

    localparam int unsigned DEF_ADDR_W   = 12;
    localparam logic [11:0] DEF_RESET_PC = 12'h000;

    typedef enum logic [1:0] {
        F_OP = 2'd0,
        F_B1 = 2'd1,
        F_B2 = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam logic [1:0] LEN1 = 2'd1;
    localparam logic [1:0] LEN2 = 2'd2;
    localparam logic [1:0] LEN3 = 2'd3;

    // The decoder reports 0 for opcodes it has no length for; treat those as single-byte.
    function automatic logic [1:0] norm_len(input logic [1:0] len);
        return (len == 2'd0) ? LEN1 : len;
    endfunction

endpackage

// File: rtl/inst_fetch_unit.sv
// Fetch stage: walks the program ROM one byte per cycle, assembles 1-3 byte
// instructions and hands them to the decoder over a valid/ready handshake.
module inst_fetch_unit
    import noobs_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset_,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        opc_byte,
    input  logic [1:0]        opc_len,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [23:0]       inst_data,
    output logic [1:0]        inst_len,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [7:0]        byte0_q, byte0_d;
    logic [7:0]        byte1_q, byte1_d;
    logic [7:0]        byte2_q, byte2_d;
    logic [1:0]        len_q, len_d;
    logic              valid_q, valid_d;

    logic              fetch_op;
    logic [1:0]        len_in;
    logic [ADDR_W-1:0] pc_inc;

    // A consumed HOLD fetches the next opcode in the same cycle, exactly like F_OP.
    assign fetch_op = (state_q == F_OP) || ((state_q == HOLD) && inst_ready);
    assign opc_byte = fetch_op ? rom_data : byte0_q;
    assign len_in   = norm_len(opc_len);
    assign pc_inc   = pc_q + ADDR_W'(1);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_pc_d = inst_pc_q;
        byte0_d   = byte0_q;
        byte1_d   = byte1_q;
        byte2_d   = byte2_q;
        len_d     = len_q;
        valid_d   = valid_q;

        if (redirect) begin
            pc_d    = redirect_pc;
            state_d = F_OP;
            valid_d = 1'b0;
        end else if (!stall) begin
            if (fetch_op) begin
                byte0_d   = rom_data;
                byte1_d   = '0;
                byte2_d   = '0;
                inst_pc_d = pc_q;
                len_d     = len_in;
                pc_d      = pc_inc;
                if (len_in == LEN1) begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                end else begin
                    state_d = F_B1;
                    valid_d = 1'b0;
                end
            end else begin
                case (state_q)
                    F_B1: begin
                        byte1_d = rom_data;
                        pc_d    = pc_inc;
                        if (len_q == LEN2) begin
                            state_d = HOLD;
                            valid_d = 1'b1;
                        end else begin
                            state_d = F_B2;
                        end
                    end
                    F_B2: begin
                        byte2_d = rom_data;
                        pc_d    = pc_inc;
                        state_d = HOLD;
                        valid_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q   <= F_OP;
            pc_q      <= RESET_PC;
            inst_pc_q <= '0;
            byte0_q   <= '0;
            byte1_q   <= '0;
            byte2_q   <= '0;
            len_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_pc_q <= inst_pc_d;
            byte0_q   <= byte0_d;
            byte1_q   <= byte1_d;
            byte2_q   <= byte2_d;
            len_q     <= len_d;
            valid_q   <= valid_d;
        end
    end

    assign rom_addr   = pc_q;
    assign inst_valid = valid_q;
    assign inst_data  = {byte0_q, byte1_q, byte2_q};
    assign inst_len   = len_q;
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: ROM + decoder length lookup, an instruction-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  opc_byte;
    logic [1:0]  opc_len;
    logic        inst_valid;
    logic        inst_ready;
    logic [23:0] inst_data;
    logic [1:0]  inst_len;
    logic [11:0] inst_pc;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        stall;

    always #5 clk = ~clk;

    inst_fetch_unit #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
        .clk         (clk),
        .reset_      (reset_),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .opc_byte    (opc_byte),
        .opc_len     (opc_len),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_len    (inst_len),
        .inst_pc     (inst_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall)
    );

    logic [7:0] rom [0:4095];
    assign rom_data = rom[rom_addr];

    // Decoder length code from the top two opcode bits: 00 -> 0 (unknown), 01 -> 1, 11 -> 2, 10 -> 3.
    function automatic logic [1:0] dec_len(input logic [7:0] b);
        case (b[7:6])
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            2'b10:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    assign opc_len = dec_len(opc_byte);

    function automatic int unsigned ilen(input logic [7:0] b);
        return (dec_len(b) == 2'd0) ? 1 : int'(dec_len(b));
    endfunction

    function automatic logic [23:0] exp_data(input logic [11:0] pc);
        logic [11:0] a1, a2;
        int unsigned l;
        a1 = pc + 12'd1;
        a2 = pc + 12'd2;
        l  = ilen(rom[pc]);
        return {rom[pc], (l >= 2) ? rom[a1] : 8'h00, (l >= 3) ? rom[a2] : 8'h00};
    endfunction

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: address of the instruction being assembled/held, and how many
    // non-stalled clock edges remain before it is presented.
    logic [11:0] m_pc;
    int unsigned m_rem;

    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            m_pc  <= 12'h000;
            m_rem <= ilen(rom[12'h000]);
        end else if (redirect) begin
            m_pc  <= redirect_pc;
            m_rem <= ilen(rom[redirect_pc]);
        end else if (stall) begin
            m_rem <= m_rem;
        end else if (m_rem == 0) begin
            if (inst_ready) begin
                m_pc  <= m_pc + 12'(ilen(rom[m_pc]));
                m_rem <= ilen(rom[12'(m_pc + 12'(ilen(rom[m_pc])))]) - 1;
            end
        end else begin
            m_rem <= m_rem - 1;
        end
    end

    always @(negedge clk) begin
        logic [11:0] ea;
        if (!reset_) begin
            check("rst_rom_addr", 32'(rom_addr), 32'h000);
            check("rst_valid", 32'(inst_valid), 32'd0);
            check("rst_data", 32'(inst_data), 32'h0);
            check("rst_len", 32'(inst_len), 32'd0);
            check("rst_pc", 32'(inst_pc), 32'h000);
        end else begin
            ea = m_pc + 12'(ilen(rom[m_pc]) - m_rem);
            check("model_rom_addr", 32'(rom_addr), 32'(ea));
            check("model_valid", 32'(inst_valid), 32'(m_rem == 0));
            if (m_rem == 0) begin
                check("model_data", 32'(inst_data), 32'(exp_data(m_pc)));
                check("model_pc", 32'(inst_pc), 32'(m_pc));
                check("model_len", 32'(inst_len), 32'(ilen(rom[m_pc])));
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'(i * 7 + 3);
        rom[12'h000] = 8'hC0;
        rom[12'h001] = 8'h04;
        rom[12'h002] = 8'h70;
        rom[12'h003] = 8'h80;
        rom[12'h004] = 8'h11;
        rom[12'h005] = 8'h22;
        rom[12'h006] = 8'h2D;
        rom[12'h024] = 8'h00;
        rom[12'hFFE] = 8'h80;
        rom[12'hFFF] = 8'hAB;

        reset_      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 12'h000;
        stall       = 1'b0;
        inst_ready  = 1'b1;

        tick(3);
        check("lit_rst_addr", 32'(rom_addr), 32'h000);
        check("lit_rst_valid", 32'(inst_valid), 32'd0);
        reset_ = 1'b1;

        // Mixed lengths, ready held high.
        tick(2);
        check("lit_i0_valid", 32'(inst_valid), 32'd1);
        check("lit_i0_data", 32'(inst_data), 32'hC00400);
        check("lit_i0_pc", 32'(inst_pc), 32'h000);
        check("lit_i0_len", 32'(inst_len), 32'd2);
        tick(1);
        check("lit_i1_valid", 32'(inst_valid), 32'd1);
        check("lit_i1_data", 32'(inst_data), 32'h700000);
        check("lit_i1_pc", 32'(inst_pc), 32'h002);
        tick(1);
        check("lit_i2_busy", 32'(inst_valid), 32'd0);
        check("lit_i2_addr", 32'(rom_addr), 32'h004);
        tick(2);
        check("lit_i2_data", 32'(inst_data), 32'h801122);
        check("lit_i2_pc", 32'(inst_pc), 32'h003);
        check("lit_i2_len", 32'(inst_len), 32'd3);

        // Backpressure.
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("lit_bp_data", 32'(inst_data), 32'h801122);
            check("lit_bp_pc", 32'(inst_pc), 32'h003);
            check("lit_bp_addr", 32'(rom_addr), 32'h006);
        end
        inst_ready = 1'b1;
        #1;
        check("lit_bp_opc", 32'(opc_byte), 32'h2D);
        tick(1);
        check("lit_bp_next_pc", 32'(inst_pc), 32'h006);
        check("lit_bp_next_data", 32'(inst_data), 32'h2D0000);

        // Wrap across the top of the address space.
        inst_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 12'hFFE;
        tick(1);
        redirect = 1'b0;
        check("lit_wr_addr0", 32'(rom_addr), 32'hFFE);
        check("lit_wr_valid0", 32'(inst_valid), 32'd0);
        tick(3);
        check("lit_wr_data", 32'(inst_data), 32'h80ABC0);
        check("lit_wr_pc", 32'(inst_pc), 32'hFFE);
        check("lit_wr_addr", 32'(rom_addr), 32'h001);
        inst_ready = 1'b1;
        tick(1);
        check("lit_wr_next_pc", 32'(inst_pc), 32'h001);
        check("lit_wr_next_len", 32'(inst_len), 32'd1);

        // Redirect during F_B1, combined with stall.
        redirect    = 1'b1;
        redirect_pc = 12'h000;
        tick(1);
        redirect = 1'b0;
        tick(1);
        check("lit_rd_b1_addr", 32'(rom_addr), 32'h001);
        redirect    = 1'b1;
        redirect_pc = 12'h024;
        stall       = 1'b1;
        tick(1);
        redirect = 1'b0;
        stall    = 1'b0;
        check("lit_rd_flush", 32'(inst_valid), 32'd0);
        check("lit_rd_addr", 32'(rom_addr), 32'h024);
        inst_ready = 1'b0;
        tick(1);
        check("lit_rd_valid", 32'(inst_valid), 32'd1);
        check("lit_rd_pc", 32'(inst_pc), 32'h024);
        check("lit_rd_data", 32'(inst_data), 32'h000000);
        check("lit_rd_len", 32'(inst_len), 32'd1);

        // Stall in F_B2.
        redirect    = 1'b1;
        redirect_pc = 12'h003;
        tick(1);
        redirect = 1'b0;
        tick(2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("lit_st_addr", 32'(rom_addr), 32'h005);
            check("lit_st_valid", 32'(inst_valid), 32'd0);
        end
        stall = 1'b0;
        tick(1);
        check("lit_st_rise", 32'(inst_valid), 32'd1);
        check("lit_st_data", 32'(inst_data), 32'h801122);

        // Handshake is not consumed while stalled.
        stall      = 1'b1;
        inst_ready = 1'b1;
        tick(2);
        check("lit_sh_pc", 32'(inst_pc), 32'h003);
        stall = 1'b0;
        tick(1);
        check("lit_sh_next", 32'(inst_pc), 32'h006);

        // Reset asserted mid-instruction.
        redirect    = 1'b1;
        redirect_pc = 12'h003;
        tick(1);
        redirect = 1'b0;
        tick(1);
        reset_ = 1'b0;
        #1;
        check("lit_mr_addr", 32'(rom_addr), 32'h000);
        check("lit_mr_valid", 32'(inst_valid), 32'd0);
        check("lit_mr_pc", 32'(inst_pc), 32'h000);
        tick(2);
        reset_ = 1'b1;
        tick(2);
        check("lit_mr_valid2", 32'(inst_valid), 32'd1);
        check("lit_mr_data", 32'(inst_data), 32'hC00400);
        check("lit_mr_ipc", 32'(inst_pc), 32'h000);

        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
